// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM lane gather/scatter block.
//   LANES        number of byte lanes per word
//   MODE_RD/WR   latched transfer direction
//   lane_state_e next lane the sequence expects (IDLE means en1 expected)
package dram_pkg;

    localparam int unsigned LANES = 4;

    localparam logic MODE_RD = 1'b0;
    localparam logic MODE_WR = 1'b1;

    // Encoding matches the lane index an in-order event must carry.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE2 = 2'd1,
        LANE3 = 2'd2,
        LANE4 = 2'd3
    } lane_state_e;

    function automatic lane_state_e state_after(input logic [1:0] lane);
        case (lane)
            2'd0:    return LANE2;
            2'd1:    return LANE3;
            2'd2:    return LANE4;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic [1:0] lane_expected(input lane_state_e st);
        return st;
    endfunction

endpackage

// File: rtl/dram_strobe_edge.sv
// Rising-edge detector for the four lane strobes.
//   clk, rst  clock and asynchronous active-high reset
//   en        strobe vector {en4, en3, en2, en1}
//   rise      per-lane rising edge this cycle
//   onehot    exactly one lane rose
//   multi     more than one lane rose
import dram_pkg::*;

module dram_strobe_edge (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] en,
    output logic [LANES-1:0] rise,
    output logic             onehot,
    output logic             multi
);

    logic [LANES-1:0] en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
        end else begin
            en_q <= en;
        end
    end

    always_comb begin
        rise   = en & ~en_q;
        // Clearing the lowest set bit leaves something only if 2+ bits were set.
        multi  = (rise & (rise - 1'b1)) != '0;
        onehot = (rise != '0) && !multi;
    end

endmodule

// File: rtl/dram_lane_gather.sv
// Memory-side responder to the DRAM address sequencer's lane strobes.
// Reads gather one byte per strobe into a word for the MAC datapath; stores
// scatter a result word into four single-cycle byte writes.
//   clk, rst     clock and asynchronous active-high reset
//   write_en     1 = store, 0 = read (latched on the en1 event)
//   en1..en4     lane strobes; only rising edges count
//   dram_rdata   byte at the current DRAM address
//   store_word   word to store, lane0 in the low byte
//   dram_wdata   byte to write, valid while dram_we is high
//   dram_we      one-cycle write pulse per stored lane
//   word_out     gathered word, valid while word_valid is high
//   word_valid   word_out holds an unconsumed word
//   word_ready   consumer accepts word_out
//   overrun      pulse: an unconsumed word was overwritten
//   seq_err      pulse: strobe protocol violation
// Optional feature: define SEQ_CHECK_EN to enable strobe-order checking and
// seq_err; without it seq_err stays 0 and out-of-order lanes are accepted.
import dram_pkg::*;

module dram_lane_gather #(
    parameter int unsigned BYTE_W        = 8,
    parameter int unsigned RD_SAMPLE_DLY = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_en,
    input  logic                en1,
    input  logic                en2,
    input  logic                en3,
    input  logic                en4,
    input  logic [BYTE_W-1:0]   dram_rdata,
    input  logic [4*BYTE_W-1:0] store_word,
    output logic [BYTE_W-1:0]   dram_wdata,
    output logic                dram_we,
    output logic [4*BYTE_W-1:0] word_out,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                overrun,
    output logic                seq_err
);

    localparam int unsigned WORD_W = 4 * BYTE_W;

    logic [LANES-1:0] rise;
    logic             rise_one;
    logic             rise_multi;

    dram_strobe_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .en     ({en4, en3, en2, en1}),
        .rise   (rise),
        .onehot (rise_one),
        .multi  (rise_multi)
    );

    lane_state_e         state_q;
    logic                mode_q;
    logic [WORD_W-1:0]   wbuf_q;
    logic [3*BYTE_W-1:0] asm_q;
    logic                pend_q;
    logic [1:0]          pend_lane_q;

    logic [1:0]        evt_lane;
    logic              evt;
    logic              start;
    logic              lane_acc;
    logic              abort;
    logic              rd_req;
    logic              wr_req;
    logic [BYTE_W-1:0] wr_byte;
    logic              cap_v;
    logic [1:0]        cap_lane;

    always_comb begin
        evt_lane = 2'd0;
        for (int k = 0; k < LANES; k++) begin
            if (rise[k]) begin
                evt_lane = 2'(k);
            end
        end

        evt   = rise_one && !rise_multi;
        start = evt && (evt_lane == 2'd0);

`ifdef SEQ_CHECK_EN
        lane_acc = evt && (evt_lane != 2'd0) && (state_q != IDLE) &&
                   (evt_lane == lane_expected(state_q)) && (write_en == mode_q);
        abort    = rise_multi || (evt && (evt_lane != 2'd0) && !lane_acc);
`else
        lane_acc = evt && (evt_lane != 2'd0) && (state_q != IDLE);
        abort    = 1'b0;
`endif

        rd_req  = (start && (write_en == MODE_RD)) || (lane_acc && (mode_q == MODE_RD));
        wr_req  = (start && (write_en == MODE_WR)) || (lane_acc && (mode_q == MODE_WR));
        // Lane0 comes straight from store_word since wbuf loads on the same edge.
        wr_byte = start ? store_word[BYTE_W-1:0] : wbuf_q[int'(evt_lane)*BYTE_W +: BYTE_W];

        if (RD_SAMPLE_DLY == 0) begin
            cap_v    = rd_req;
            cap_lane = evt_lane;
        end else begin
            cap_v    = pend_q;
            cap_lane = pend_lane_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_RD;
            wbuf_q      <= '0;
            asm_q       <= '0;
            pend_q      <= 1'b0;
            pend_lane_q <= 2'd0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            overrun     <= 1'b0;
            seq_err     <= 1'b0;
            dram_we     <= 1'b0;
            dram_wdata  <= '0;
        end else begin
            dram_we <= wr_req;
            if (wr_req) begin
                dram_wdata <= wr_byte;
            end
            seq_err     <= abort;
            overrun     <= 1'b0;
            pend_q      <= rd_req;
            pend_lane_q <= evt_lane;

            if (abort) begin
                state_q <= IDLE;
            end else if (start) begin
                state_q <= LANE2;
                mode_q  <= write_en;
                if (write_en == MODE_WR) begin
                    wbuf_q <= store_word;
                end
            end else if (lane_acc) begin
                state_q <= state_after(evt_lane);
            end

            // A completing word wins over a pure accept; with ready high the
            // old word is consumed on this same edge, so no overrun.
            if (cap_v && (cap_lane == 2'd3)) begin
                word_out   <= {dram_rdata, asm_q};
                word_valid <= 1'b1;
                overrun    <= word_valid && !word_ready;
            end else begin
                if (cap_v) begin
                    asm_q[int'(cap_lane)*BYTE_W +: BYTE_W] <= dram_rdata;
                end
                if (word_valid && word_ready) begin
                    word_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_lane_gather.sv
// Self-checking bench for dram_lane_gather (BYTE_W=8, RD_SAMPLE_DLY=0).
// Table of read/store transactions plus hand sequences for overrun,
// same-edge accept, held strobes, strobe faults and mid-sequence reset.
module tb_dram_lane_gather;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic        en1, en2, en3, en4;
    logic [7:0]  dram_rdata;
    logic [31:0] store_word;
    logic [7:0]  dram_wdata;
    logic        dram_we;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        overrun;
    logic        seq_err;

    dram_lane_gather #(
        .BYTE_W        (8),
        .RD_SAMPLE_DLY (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .en1        (en1),
        .en2        (en2),
        .en3        (en3),
        .en4        (en4),
        .dram_rdata (dram_rdata),
        .store_word (store_word),
        .dram_wdata (dram_wdata),
        .dram_we    (dram_we),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overrun    (overrun),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ov_cnt = 0;
    int se_cnt = 0;

    logic [31:0] wq[$];
    logic [7:0]  bq[$];

    typedef struct {
        bit          is_store;
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] sw;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: words popped on accept, bytes popped on each write pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word_extra: got %0h expected none", word_out);
                end else begin
                    check("word", word_out, wq.pop_front());
                end
            end
            if (dram_we) begin
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wbyte_extra: got %0h expected none", dram_wdata);
                end else begin
                    check("wbyte", {24'h0, dram_wdata}, {24'h0, bq.pop_front()});
                end
            end
            if (overrun) ov_cnt++;
            if (seq_err) se_cnt++;
        end
    end

    task automatic pulse(input logic [3:0] en_v, input logic [7:0] d);
        {en4, en3, en2, en1} = en_v;
        dram_rdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        {en4, en3, en2, en1} = 4'b0000;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_read(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input bit push, input logic [31:0] exp);
        if (push) wq.push_back(exp);
        write_en = 1'b0;
        pulse(4'b0001, b0);
        pulse(4'b0010, b1);
        pulse(4'b0100, b2);
        pulse(4'b1000, b3);
    endtask

    task automatic run_store(input logic [31:0] sw, input logic [31:0] exp);
        for (int k = 0; k < 4; k++) bq.push_back(exp[8*k +: 8]);
        write_en   = 1'b1;
        store_word = sw;
        pulse(4'b0001, 8'h00);
        pulse(4'b0010, 8'h00);
        pulse(4'b0100, 8'h00);
        pulse(4'b1000, 8'h00);
        write_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 32'h0, 32'h44332211};
        vecs[1] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'h5A, 8'hA5, 32'h0, 32'hA55AFF00};
        vecs[3] = '{1'b0, 8'h80, 8'h01, 8'h7F, 8'hFE, 32'h0, 32'hFE7F0180};
        vecs[4] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 32'h01234567, 32'h01234567};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 32'hA5C30F96, 32'hA5C30F96};

        rst = 1'b1;
        write_en = 1'b0;
        {en4, en3, en2, en1} = 4'b0000;
        dram_rdata = 8'h00;
        store_word = 32'h0;
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_word_out", word_out, 32'h0);
        check("rst_word_valid", {31'h0, word_valid}, 32'h0);
        check("rst_dram_we", {31'h0, dram_we}, 32'h0);
        check("rst_dram_wdata", {24'h0, dram_wdata}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_seq_err", {31'h0, seq_err}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Table-driven reads and stores with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_store) begin
                run_store(vecs[i].sw, vecs[i].exp);
                idle(3);
                check("store_no_valid", {31'h0, word_valid}, 32'h0);
            end else begin
                run_read(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, 1'b1, vecs[i].exp);
                idle(3);
                check("read_valid_drop", {31'h0, word_valid}, 32'h0);
            end
        end
        check("table_words_left", wq.size(), 0);
        check("table_bytes_left", bq.size(), 0);

        // Overrun: two back-to-back words with no consumer.
        ov_cnt = 0;
        word_ready = 1'b0;
        run_read(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 32'h0);
        run_read(8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b0, 32'h0);
        idle(2);
        check("overrun_count", ov_cnt, 1);
        check("overrun_word", word_out, 32'hD4C3B2A1);
        check("overrun_valid", {31'h0, word_valid}, 32'h1);
        wq.push_back(32'hD4C3B2A1);
        word_ready = 1'b1;
        idle(2);
        check("overrun_drained", wq.size(), 0);

        // Completion and accept on the same edge.
        ov_cnt = 0;
        word_ready = 1'b0;
        run_read(8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 32'h0);
        write_en = 1'b0;
        pulse(4'b0001, 8'h55);
        pulse(4'b0010, 8'h66);
        pulse(4'b0100, 8'h77);
        wq.push_back(32'h40302010);
        wq.push_back(32'h88776655);
        word_ready = 1'b1;
        pulse(4'b1000, 8'h88);
        idle(3);
        check("same_edge_overrun", ov_cnt, 0);
        check("same_edge_drained", wq.size(), 0);

        // en4 held across START while the next en1 rises.
        wq.push_back(32'h04030201);
        wq.push_back(32'h0D0C0B0A);
        pulse(4'b0001, 8'h01);
        pulse(4'b0010, 8'h02);
        pulse(4'b0100, 8'h03);
        pulse(4'b1000, 8'h04);
        pulse(4'b1000, 8'hEE);
        pulse(4'b1001, 8'h0A);
        pulse(4'b0010, 8'h0B);
        pulse(4'b0100, 8'h0C);
        pulse(4'b1000, 8'h0D);
        idle(3);
        check("held_en4_drained", wq.size(), 0);

        se_cnt = 0;
`ifdef SEQ_CHECK_EN
        // en1 then en3: violation, no word; a clean sequence follows.
        pulse(4'b0001, 8'h91);
        pulse(4'b0100, 8'h93);
        idle(3);
        check("seq_err_count", se_cnt, 1);
        check("seq_err_no_valid", {31'h0, word_valid}, 32'h0);
        run_read(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b1, 32'hC4C3C2C1);
        idle(3);
        check("seq_err_recover", wq.size(), 0);
`else
        // Out-of-order lanes land in their own index.
        wq.push_back(32'h44332211);
        pulse(4'b0001, 8'h11);
        pulse(4'b0100, 8'h33);
        pulse(4'b0010, 8'h22);
        pulse(4'b1000, 8'h44);
        idle(3);
        check("out_of_order", wq.size(), 0);

        // Simultaneous rising strobes are ignored.
        wq.push_back(32'hE4E3E2E1);
        pulse(4'b0001, 8'hE1);
        pulse(4'b0110, 8'h99);
        pulse(4'b0000, 8'h99);
        pulse(4'b0010, 8'hE2);
        pulse(4'b0100, 8'hE3);
        pulse(4'b1000, 8'hE4);
        idle(3);
        check("multi_strobe", wq.size(), 0);
        check("seq_err_tied", se_cnt, 0);
`endif

        // Reset mid-store with an unconsumed word held.
        word_ready = 1'b0;
        run_read(8'h5A, 8'h5B, 8'h5C, 8'h5D, 1'b0, 32'h0);
        idle(1);
        write_en   = 1'b1;
        store_word = 32'hCAFEF00D;
        bq.push_back(8'h0D);
        pulse(4'b0001, 8'h00);
        {en4, en3, en2, en1} = 4'b0010;
        @(posedge clk);
        #1;
        {en4, en3, en2, en1} = 4'b0000;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_dram_we", {31'h0, dram_we}, 32'h0);
        check("midrst_word_valid", {31'h0, word_valid}, 32'h0);
        check("midrst_word_out", word_out, 32'h0);
        check("midrst_dram_wdata", {24'h0, dram_wdata}, 32'h0);
        #1;
        rst = 1'b0;
        write_en = 1'b0;
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        run_read(8'h71, 8'h72, 8'h73, 8'h74, 1'b1, 32'h74737271);
        idle(3);
        check("midrst_recover", wq.size(), 0);
        check("final_bytes_left", bq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
